// File: rtl/pad_in_bank.sv
// Multi-channel pad input bank: pull resolution, clock-domain synchroniser,
// programmable debounce, edge/level event detection and sticky pending flags.
module pad_in_bank #(
  parameter int NCH         = 8,
  parameter int DEB_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NCH-1:0]     pad,
  input  logic [NCH-1:0]     ie,
  input  logic [NCH-1:0]     pu,
  input  logic [NCH-1:0]     pd,
  input  logic [DEB_W-1:0]   deb_thr,
  input  logic [2*NCH-1:0]   irq_mode,
  input  logic [NCH-1:0]     irq_en,
  input  logic [NCH-1:0]     irq_clr,
  output logic [NCH-1:0]     dc_raw,
  output logic [NCH-1:0]     dc,
  output logic [NCH-1:0]     irq_pend,
  output logic               irq
);

  logic [NCH-1:0]   resolved;
  logic [NCH-1:0]   sync_q [SYNC_STAGES];
  logic [NCH-1:0]   sync_s;
  logic [DEB_W-1:0] cnt_q  [NCH];
  logic [DEB_W-1:0] cnt_d  [NCH];
  logic [NCH-1:0]   dc_q, dc_d;
  logic [NCH-1:0]   dc_dly_q;
  logic [NCH-1:0]   evt;
  logic [NCH-1:0]   pend_q, pend_d;

  // Floating channels resolve to 0 so no X/Z ever reaches the synchroniser.
  always_comb begin
    resolved = '0;
    for (int i = 0; i < NCH; i++) begin
      if (ie[i])      resolved[i] = pad[i];
      else if (pu[i]) resolved[i] = 1'b1;
      else if (pd[i]) resolved[i] = 1'b0;
      else            resolved[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= resolved;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

  // The >= compare lets a lowered threshold commit immediately and keeps cnt from wrapping.
  always_comb begin
    dc_d = dc_q;
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i] = '0;
      if (sync_s[i] != dc_q[i]) begin
        if (cnt_q[i] >= deb_thr) dc_d[i] = sync_s[i];
        else                     cnt_d[i] = cnt_q[i] + DEB_W'(1);
      end
    end
  end

  always_comb begin
    evt = '0;
    for (int i = 0; i < NCH; i++) begin
      case (irq_mode[2*i +: 2])
        2'b00:   evt[i] = dc_q[i] & ~dc_dly_q[i];
        2'b01:   evt[i] = ~dc_q[i] & dc_dly_q[i];
        2'b10:   evt[i] = dc_q[i] ^ dc_dly_q[i];
        default: evt[i] = dc_q[i];
      endcase
    end
  end

  // A qualifying event wins over a clear strobe in the same cycle.
  assign pend_d = (evt & irq_en) | (pend_q & ~irq_clr);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
      dc_q     <= '0;
      dc_dly_q <= '0;
      pend_q   <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) cnt_q[i] <= cnt_d[i];
      dc_q     <= dc_d;
      dc_dly_q <= dc_q;
      pend_q   <= pend_d;
    end
  end

  assign dc_raw   = sync_s;
  assign dc       = dc_q;
  assign irq_pend = pend_q;
  assign irq      = |pend_q;

endmodule

// File: doc/pad_in_bank.md
Name: pad_in_bank

Overview:
- Parametrised multi-channel successor to the single-pad input cell.
- Per channel: input-enable/pull resolution, clock-domain synchronisation, programmable debounce filter, edge/level event detection, sticky interrupt-pending bits.
- Sits between the chip input pads and the GPIO/peripheral register block.
- Drives one combined interrupt line to the interrupt controller.

Parameters:
- NCH, 8: number of input channels.
- DEB_W, 8: debounce counter / threshold width.
- SYNC_STAGES, 2: synchroniser flops per channel (minimum 2).

Ports:
- clk  input  1  block clock.
- rstn  input  1  asynchronous active-low reset.
- pad  input  NCH  raw pad inputs, asynchronous to clk.
- ie  input  NCH  per-channel input enable.
- pu  input  NCH  per-channel pull-up select, used when ie=0.
- pd  input  NCH  per-channel pull-down select, used when ie=0 and pu=0.
- deb_thr  input  DEB_W  debounce threshold, shared by all channels.
- irq_mode  input  2*NCH  per-channel event mode; bits [2i+1:2i] belong to channel i.
- irq_en  input  NCH  per-channel event enable.
- irq_clr  input  NCH  per-channel pending clear, single-cycle strobe.
- dc_raw  output  NCH  synchronised, unfiltered level.
- dc  output  NCH  debounced level.
- irq_pend  output  NCH  sticky pending flags.
- irq  output  1  OR of irq_pend.

Behaviour:
- Resolution (combinational, per channel): r = ie ? pad : pu ? 1 : pd ? 0 : 0.
  - Floating (ie=pu=pd=0) resolves to 0; no X/Z enters the synchroniser.
- Synchroniser: SYNC_STAGES flops on r; last stage is s, driven on dc_raw. All stages reset to 0.
- Debounce (per channel, counter cnt of DEB_W bits, dc register):
  - s == dc: cnt <= 0.
  - s != dc and cnt >= deb_thr: dc <= s, cnt <= 0.
  - s != dc and cnt < deb_thr: cnt <= cnt+1.
  - deb_thr=0: dc follows s one cycle later.
  - Pad step to dc change: SYNC_STAGES + deb_thr + 1 cycles.
  - A glitch shorter than deb_thr+1 cycles at s never reaches dc; the counter restarts on every bounce back.
  - Lowering deb_thr mid-count below cnt commits on the next cycle, because the compare is >=.
  - cnt never wraps: it resets when it reaches the threshold.
- Event detect: dc_q is dc delayed one cycle, reset 0. Modes:
  - 00: rise (dc & ~dc_q).
  - 01: fall (~dc & dc_q).
  - 10: both edges.
  - 11: level-high (dc).
- Pending (per channel), evaluated each cycle:
  - event & irq_en: irq_pend <= 1. Set wins over a simultaneous irq_clr.
  - otherwise irq_clr: irq_pend <= 0.
  - otherwise hold.
  - Level mode: pending re-asserts every cycle while dc=1, so clear is effective only after dc falls.
  - Dropping irq_en does not clear pending.
  - Changing irq_mode takes effect the next cycle; no spurious event is generated by a mode change alone.
- irq: registered OR of irq_pend, i.e. the combinational OR of the pending flops. It asserts the cycle after the qualifying dc change.
- Reset: all synchroniser stages, cnt, dc, dc_q and irq_pend go to 0.
  - Outputs after reset: dc_raw=0, dc=0, irq_pend=0, irq=0.
  - Reset asserted mid-debounce abandons the count.
  - After release, a pad held at 1 (or pu=1 with ie=0) produces a normal rise after the full latency. If mode is rise, that rise sets pending.
- Channels are fully independent; only deb_thr is shared.

Test Plan:
- Reset / pull-up: rstn low with pad=0xFF, ie=0xFF; then release; deb_thr=3.
  -> All outputs 0 during reset.
  -> dc_raw=0xFF 2 cycles after release; dc=0xFF 6 cycles after release.
  -> With irq_mode=00, irq_en=0xFF: irq_pend=0xFF, irq=1 on cycle 7.
- Pull resolution: ie=0, then pu=1/pd=0 -> ch0 dc=1; pu=0/pd=1 -> dc=0; pu=pd=0 -> dc=0. Pad toggling meanwhile has no effect on dc_raw.
- Glitch filter: deb_thr=4, ch1 pad pulses high for 3 cycles then low.
  -> dc_raw shows the pulse; dc stays 0; irq_pend[1] stays 0.
  -> A 6-cycle pulse gives dc[1]=1 5 cycles after dc_raw rises.
- Edge modes: ch2=rise, ch3=fall, ch4=both, all driven by the same clean 0->1->0 pulse, deb_thr=0.
  -> ch2 pends on the rise, ch3 on the fall, ch4 on both.
  -> ch4 cleared between the edges re-pends on the fall.
- Set/clear collision: ch5 mode 10; irq_clr[5] in the exact cycle a qualifying edge occurs -> irq_pend[5]=1. An irq_clr one cycle later -> irq_pend[5]=0, irq=0.
- Level mode / enable: ch6 mode 11 held high; irq_clr[6] pulsed -> irq_pend[6] stays 1.
  -> irq_en[6]=0 -> pend remains 1 until cleared; clear then sticks, since pending no longer sets with irq_en=0.
